// File: rtl/alu_writeback.sv
// ALU writeback stage: flags register plus a 2-entry in-order register-file write queue.
// Optional forwarding lookup over pending writes is enabled by defining ALU_WB_FWD_EN.
module alu_writeback #(
   parameter int DATA_W  = 32,
   parameter int FLAGS_W = 8,
   parameter int ADDR_W  = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_result,
   input  logic [FLAGS_W-1:0] in_flags,
   input  logic [ADDR_W-1:0]  in_rd,
   input  logic               in_wr_en,
   input  logic               in_flags_en,
   output logic [FLAGS_W-1:0] flags_q,
   output logic               rf_we,
   output logic [ADDR_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata,
   input  logic               rf_ready,
   input  logic [ADDR_W-1:0]  lookup_rd,
   output logic               lookup_hit,
   output logic [DATA_W-1:0]  lookup_data
);

   logic               head_valid_r, tail_valid_r;
   logic [ADDR_W-1:0]  head_rd_r, tail_rd_r;
   logic [DATA_W-1:0]  head_data_r, tail_data_r;
   logic [FLAGS_W-1:0] flags_r;

   logic               accept_s, push_s, pop_s;
   logic               shift_hv_s, shift_tv_s;
   logic [ADDR_W-1:0]  shift_hr_s, shift_tr_s;
   logic [DATA_W-1:0]  shift_hd_s, shift_td_s;
   logic               next_hv_s, next_tv_s;
   logic [ADDR_W-1:0]  next_hr_s, next_tr_s;
   logic [DATA_W-1:0]  next_hd_s, next_td_s;

   // Ready depends only on registered occupancy: full exactly when the tail slot is occupied.
   assign in_ready = ~tail_valid_r;
   assign accept_s = in_valid & ~tail_valid_r;
   assign push_s   = accept_s & in_wr_en & (in_rd != {ADDR_W{1'b0}});
   assign pop_s    = head_valid_r & rf_ready;

   assign flags_q  = flags_r;
   // Gated by reset so a pending head is never offered to the register file during reset.
   assign rf_we    = head_valid_r & rst_n;
   assign rf_waddr = head_rd_r;
   assign rf_wdata = head_data_r;

   // Pop stage: popping moves the tail into the head slot and empties the tail.
   always_comb begin
      if (pop_s) begin
         shift_hv_s = tail_valid_r;
         shift_hr_s = tail_rd_r;
         shift_hd_s = tail_data_r;
         shift_tv_s = 1'b0;
         shift_tr_s = {ADDR_W{1'b0}};
         shift_td_s = {DATA_W{1'b0}};
      end else begin
         shift_hv_s = head_valid_r;
         shift_hr_s = head_rd_r;
         shift_hd_s = head_data_r;
         shift_tv_s = tail_valid_r;
         shift_tr_s = tail_rd_r;
         shift_td_s = tail_data_r;
      end
   end

   // Push stage: a new entry lands in the first free slot after the pop.
   always_comb begin
      if (push_s && !shift_hv_s) begin
         next_hv_s = 1'b1;
         next_hr_s = in_rd;
         next_hd_s = in_result;
         next_tv_s = shift_tv_s;
         next_tr_s = shift_tr_s;
         next_td_s = shift_td_s;
      end else if (push_s) begin
         next_hv_s = shift_hv_s;
         next_hr_s = shift_hr_s;
         next_hd_s = shift_hd_s;
         next_tv_s = 1'b1;
         next_tr_s = in_rd;
         next_td_s = in_result;
      end else begin
         next_hv_s = shift_hv_s;
         next_hr_s = shift_hr_s;
         next_hd_s = shift_hd_s;
         next_tv_s = shift_tv_s;
         next_tr_s = shift_tr_s;
         next_td_s = shift_td_s;
      end
   end

   // Queue and flags state; empty slots are kept at zero so idle outputs read as zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_valid_r <= 1'b0;
         head_rd_r    <= {ADDR_W{1'b0}};
         head_data_r  <= {DATA_W{1'b0}};
         tail_valid_r <= 1'b0;
         tail_rd_r    <= {ADDR_W{1'b0}};
         tail_data_r  <= {DATA_W{1'b0}};
         flags_r      <= {FLAGS_W{1'b0}};
      end else begin
         head_valid_r <= next_hv_s;
         head_rd_r    <= next_hr_s;
         head_data_r  <= next_hd_s;
         tail_valid_r <= next_tv_s;
         tail_rd_r    <= next_tr_s;
         tail_data_r  <= next_td_s;
         if (accept_s && in_flags_en) begin
            flags_r <= in_flags;
         end else begin
            flags_r <= flags_r;
         end
      end
   end

`ifdef ALU_WB_FWD_EN
   logic hit_head_s, hit_tail_s;

   assign hit_head_s = head_valid_r & (head_rd_r == lookup_rd) & (lookup_rd != {ADDR_W{1'b0}});
   assign hit_tail_s = tail_valid_r & (tail_rd_r == lookup_rd) & (lookup_rd != {ADDR_W{1'b0}});
   assign lookup_hit = hit_head_s | hit_tail_s;

   // Youngest matching entry wins, so the tail has priority over the head.
   always_comb begin
      if (hit_tail_s) begin
         lookup_data = tail_data_r;
      end else if (hit_head_s) begin
         lookup_data = head_data_r;
      end else begin
         lookup_data = {DATA_W{1'b0}};
      end
   end
`else
   logic lookup_unused_s;

   assign lookup_unused_s = ^lookup_rd;
   assign lookup_hit      = 1'b0;
   assign lookup_data     = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized traffic against a queue model.
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [7:0]  in_flags;
   logic [4:0]  in_rd;
   logic        in_wr_en;
   logic        in_flags_en;
   logic [7:0]  flags_q;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        rf_ready;
   logic [4:0]  lookup_rd;
   logic        lookup_hit;
   logic [31:0] lookup_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t       mq[$];
   logic [7:0] m_flags = 8'h00;

   always #5 clk = ~clk;

   alu_writeback dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd), .in_wr_en(in_wr_en),
      .in_flags_en(in_flags_en), .flags_q(flags_q), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .rf_ready(rf_ready), .lookup_rd(lookup_rd),
      .lookup_hit(lookup_hit), .lookup_data(lookup_data)
   );

   // Advance one clock, applying the specified rules to the reference queue, then settle at the falling edge.
   task automatic tick();
      logic acc;
      logic pop;
      ent_t e;
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_flags = 8'h00;
      end else begin
         acc = in_valid && (mq.size() < 2);
         pop = (mq.size() > 0) && rf_ready;
         if (pop) void'(mq.pop_front());
         if (acc && in_flags_en) m_flags = in_flags;
         if (acc && in_wr_en && in_rd != 5'd0) begin
            e.rd   = in_rd;
            e.data = in_result;
            mq.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   function automatic logic exp_ready();
      return mq.size() < 2;
   endfunction

   function automatic logic exp_we();
      return rst_n && (mq.size() > 0);
   endfunction

   function automatic logic [4:0] exp_waddr();
      return (mq.size() > 0) ? mq[0].rd : 5'd0;
   endfunction

   function automatic logic [31:0] exp_wdata();
      return (mq.size() > 0) ? mq[0].data : 32'd0;
   endfunction

   function automatic logic exp_hit();
      logic h = 1'b0;
`ifdef ALU_WB_FWD_EN
      foreach (mq[i]) if (lookup_rd != 5'd0 && mq[i].rd == lookup_rd) h = 1'b1;
`endif
      return h;
   endfunction

   function automatic logic [31:0] exp_ldata();
      logic [31:0] d = 32'd0;
`ifdef ALU_WB_FWD_EN
      foreach (mq[i]) if (lookup_rd != 5'd0 && mq[i].rd == lookup_rd) d = mq[i].data;
`endif
      return d;
   endfunction

   task automatic idle_inputs();
      in_valid    = 1'b0;
      in_result   = 32'd0;
      in_flags    = 8'h00;
      in_rd       = 5'd0;
      in_wr_en    = 1'b0;
      in_flags_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_wr_en = 1'b1; in_flags_en = 1'b1;
      in_flags = 8'hFF; in_rd = 5'd7; in_result = 32'h1234; rf_ready = 1'b0; lookup_rd = 5'd7;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks += 7;
         if (in_ready !== 1'b1)      begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
         if (flags_q !== 8'h00)      begin errors++; $display("FAIL reset_flags: got %h want 00", flags_q); end
         if (rf_we !== 1'b0)         begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
         if (rf_waddr !== 5'd0)      begin errors++; $display("FAIL reset_waddr: got %h want 0", rf_waddr); end
         if (rf_wdata !== 32'd0)     begin errors++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
         if (lookup_hit !== 1'b0)    begin errors++; $display("FAIL reset_lhit: got %b want 0", lookup_hit); end
         if (lookup_data !== 32'd0)  begin errors++; $display("FAIL reset_ldata: got %h want 0", lookup_data); end
      end
      rst_n = 1'b1;
      idle_inputs();
      tick();
   endtask

   task automatic test_single_write();
      in_valid = 1'b1; in_rd = 5'd3; in_result = 32'h0000_002A; in_flags = 8'h02;
      in_flags_en = 1'b1; in_wr_en = 1'b1; rf_ready = 1'b1;
      tick();
      idle_inputs();
      checks += 4;
      if (rf_we !== 1'b1)           begin errors++; $display("FAIL single_we: got %b want 1", rf_we); end
      if (rf_waddr !== 5'd3)        begin errors++; $display("FAIL single_waddr: got %0d want 3", rf_waddr); end
      if (rf_wdata !== 32'h2A)      begin errors++; $display("FAIL single_wdata: got %h want 2a", rf_wdata); end
      if (flags_q !== 8'h02)        begin errors++; $display("FAIL single_flags: got %h want 02", flags_q); end
      tick();
      checks += 2;
      if (rf_we !== 1'b0)           begin errors++; $display("FAIL single_we_after: got %b want 0", rf_we); end
      if (flags_q !== 8'h02)        begin errors++; $display("FAIL single_flags_hold: got %h want 02", flags_q); end
   endtask

   task automatic test_stall_fill();
      rf_ready = 1'b0;
      in_valid = 1'b1; in_wr_en = 1'b1; in_rd = 5'd1; in_result = 32'h11;
      tick();
      checks++;
      if (in_ready !== 1'b1)        begin errors++; $display("FAIL stall_ready1: got %b want 1", in_ready); end
      in_rd = 5'd2; in_result = 32'h22;
      tick();
      in_rd = 5'd5; in_result = 32'h55;
      checks += 3;
      if (in_ready !== 1'b0)        begin errors++; $display("FAIL stall_full_ready: got %b want 0", in_ready); end
      if (rf_waddr !== 5'd1)        begin errors++; $display("FAIL stall_head_addr: got %0d want 1", rf_waddr); end
      if (rf_wdata !== 32'h11)      begin errors++; $display("FAIL stall_head_data: got %h want 11", rf_wdata); end
      rf_ready = 1'b1;
      tick();
      idle_inputs();
      checks += 3;
      if (in_ready !== 1'b1)        begin errors++; $display("FAIL stall_ready_after_pop: got %b want 1", in_ready); end
      if (rf_waddr !== 5'd2)        begin errors++; $display("FAIL stall_second_addr: got %0d want 2", rf_waddr); end
      if (rf_wdata !== 32'h22)      begin errors++; $display("FAIL stall_second_data: got %h want 22", rf_wdata); end
      tick();
      checks++;
      if (rf_we !== 1'b0)           begin errors++; $display("FAIL stall_drained_we: got %b want 0", rf_we); end
   endtask

   task automatic test_nowrite_r0();
      rf_ready = 1'b1;
      in_valid = 1'b1; in_wr_en = 1'b0; in_flags_en = 1'b1; in_flags = 8'h05; in_rd = 5'd9; in_result = 32'h77;
      tick();
      checks += 2;
      if (rf_we !== 1'b0)           begin errors++; $display("FAIL cmp_we: got %b want 0", rf_we); end
      if (flags_q !== 8'h05)        begin errors++; $display("FAIL cmp_flags: got %h want 05", flags_q); end
      in_wr_en = 1'b1; in_rd = 5'd0; in_result = 32'hFF; in_flags = 8'h0A;
      tick();
      idle_inputs();
      checks += 2;
      if (rf_we !== 1'b0)           begin errors++; $display("FAIL r0_we: got %b want 0", rf_we); end
      if (flags_q !== 8'h0A)        begin errors++; $display("FAIL r0_flags: got %h want 0a", flags_q); end
   endtask

   task automatic test_back_to_back();
      rf_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_wr_en = 1'b1; in_rd = 5'(i + 1); in_result = 32'(100 + i);
         tick();
         checks += 4;
         if (rf_we !== 1'b1)         begin errors++; $display("FAIL b2b_we[%0d]: got %b want 1", i, rf_we); end
         if (rf_waddr !== 5'(i + 1)) begin errors++; $display("FAIL b2b_waddr[%0d]: got %0d want %0d", i, rf_waddr, i + 1); end
         if (rf_wdata !== 32'(100 + i)) begin errors++; $display("FAIL b2b_wdata[%0d]: got %0d want %0d", i, rf_wdata, 100 + i); end
         if (in_ready !== 1'b1)      begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_forward();
      logic        want_hit;
      logic [31:0] want_data;
`ifdef ALU_WB_FWD_EN
      want_hit = 1'b1; want_data = 32'hB;
`else
      want_hit = 1'b0; want_data = 32'h0;
`endif
      rf_ready = 1'b0; lookup_rd = 5'd4;
      in_valid = 1'b1; in_wr_en = 1'b1; in_rd = 5'd4; in_result = 32'hA;
      tick();
      in_result = 32'hB;
      tick();
      idle_inputs();
      checks += 2;
      if (lookup_hit !== want_hit)   begin errors++; $display("FAIL fwd_hit: got %b want %b", lookup_hit, want_hit); end
      if (lookup_data !== want_data) begin errors++; $display("FAIL fwd_data: got %h want %h", lookup_data, want_data); end
      lookup_rd = 5'd5;
      #1;
      checks += 2;
      if (lookup_hit !== 1'b0)       begin errors++; $display("FAIL fwd_miss_hit: got %b want 0", lookup_hit); end
      if (lookup_data !== 32'd0)     begin errors++; $display("FAIL fwd_miss_data: got %h want 0", lookup_data); end
      lookup_rd = 5'd0;
      #1;
      checks++;
      if (lookup_hit !== 1'b0)       begin errors++; $display("FAIL fwd_r0_hit: got %b want 0", lookup_hit); end
      lookup_rd = 5'd4;
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0; rf_ready = 1'b1;
      #1;
      checks += 2;
      if (in_ready !== 1'b0)         begin errors++; $display("FAIL midrst_full_before: got %b want 0", in_ready); end
      if (rf_we !== 1'b0)            begin errors++; $display("FAIL midrst_we_in_reset: got %b want 0", rf_we); end
      tick();
      rst_n = 1'b1;
      checks += 3;
      if (in_ready !== 1'b1)         begin errors++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
      if (rf_we !== 1'b0)            begin errors++; $display("FAIL midrst_we: got %b want 0", rf_we); end
      if (lookup_hit !== 1'b0)       begin errors++; $display("FAIL midrst_lhit: got %b want 0", lookup_hit); end
      tick();
      checks++;
      if (rf_we !== 1'b0)            begin errors++; $display("FAIL midrst_we_later: got %b want 0", rf_we); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst_n       = ($urandom_range(0, 59) != 0);
         in_valid    = ($urandom_range(0, 3) != 0);
         in_wr_en    = ($urandom_range(0, 4) != 0);
         in_flags_en = $urandom_range(0, 1) == 1;
         in_flags    = 8'($urandom);
         in_rd       = 5'($urandom_range(0, 7));
         in_result   = $urandom;
         rf_ready    = ($urandom_range(0, 2) != 0);
         lookup_rd   = 5'($urandom_range(0, 7));
         #1;
         checks += 7;
         if (in_ready !== exp_ready())     begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_ready, exp_ready()); end
         if (flags_q !== m_flags)          begin errors++; $display("FAIL rnd_flags[%0d]: got %h want %h", c, flags_q, m_flags); end
         if (rf_we !== exp_we())           begin errors++; $display("FAIL rnd_we[%0d]: got %b want %b", c, rf_we, exp_we()); end
         if (rf_waddr !== exp_waddr())     begin errors++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d", c, rf_waddr, exp_waddr()); end
         if (rf_wdata !== exp_wdata())     begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, rf_wdata, exp_wdata()); end
         if (lookup_hit !== exp_hit())     begin errors++; $display("FAIL rnd_lhit[%0d]: got %b want %b", c, lookup_hit, exp_hit()); end
         if (lookup_data !== exp_ldata())  begin errors++; $display("FAIL rnd_ldata[%0d]: got %h want %h", c, lookup_data, exp_ldata()); end
         tick();
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_write();
      test_stall_fill();
      test_nowrite_r0();
      test_back_to_back();
      test_forward();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
